// File: rtl/slot_pkg.sv
// slot_pkg
// Shared types and constants for the two-reel stop controller:
//   state_t     FSM state encoding (IDLE, SPIN_BOTH, SPIN2, DONE)
//   REEL_*      reel digit limit and per-tick step sizes
//   SEG_TABLE   active-high a..g patterns for digits 0..9 (bit 0 = a)
//   reel_add    mod-10 add, valid for digit 0..9 and step 0..9
//   seg_decode  digit to segment pattern, blank for anything above 9
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SPIN_BOTH = 2'd1,
    SPIN2     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [3:0] REEL_MAX   = 4'd9;
  localparam logic [3:0] REEL1_STEP = 4'd1;
  localparam logic [3:0] REEL2_STEP = 4'd3;

  // Element 9 is leftmost so SEG_TABLE[d] selects digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  function automatic logic [3:0] reel_add(input logic [3:0] v, input logic [3:0] step);
    logic [4:0] s;
    s = {1'b0, v} + {1'b0, step};
    if (s > {1'b0, REEL_MAX}) s = s - 5'd10;
    return s[3:0];
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > REEL_MAX) return 7'b0;
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchronizer, level debouncer and rising-edge pulse for one button.
//   clk, rst_n  clock and async active-low reset
//   btn         raw asynchronous button input, active-high
//   pulse       one-cycle pulse when a new high level is accepted
// A level is accepted once the synchronized input has differed from the
// accepted level for DB_CYCLES consecutive cycles; any bounce restarts the count.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          settle;

  assign settle = (s2 != level) && (cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      pulse <= settle && s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reel_stop_ctrl.sv
// reel_stop_ctrl
// Two-reel slot controller: start spins both reels, stop1 freezes reel 1,
// stop2 freezes reel 2 and raises judge.
//   clk, rst_n               clock and async active-low reset
//   btn_start/stop1/stop2    raw asynchronous buttons, active-high
//   reel1, reel2             current reel digits 0..9
//   judge                    high while both reels are stopped (DONE)
//   seg1, seg2               a..g segment patterns of reel1/reel2
// Build option: define SEG7_OUT_EN to drive seg1/seg2 from the digit decoder;
// otherwise both are tied to 0 and no decoder exists.
//
// state     | meaning
// IDLE      | after reset, waiting for start
// SPIN_BOTH | both reels advancing
// SPIN2     | reel 1 frozen, reel 2 advancing
// DONE      | both frozen, judge high, start resumes spinning
module reel_stop_ctrl
  import slot_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int SPIN_DIV  = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop1,
  input  logic       btn_stop2,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic       judge,
  output logic [6:0] seg1,
  output logic [6:0] seg2
);

  localparam int TW = $clog2(SPIN_DIV + 1);

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tick_cnt;
  logic          start_p;
  logic          stop1_p;
  logic          stop2_p;
  logic          spinning;
  logic          tick;
  logic          adv1;
  logic          adv2;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn(btn_start), .pulse(start_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop1 (
    .clk(clk), .rst_n(rst_n), .btn(btn_stop1), .pulse(stop1_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop2 (
    .clk(clk), .rst_n(rst_n), .btn(btn_stop2), .pulse(stop2_p)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start_p) state_nx = SPIN_BOTH;
      SPIN_BOTH:  if (stop1_p) state_nx = SPIN2;
      SPIN2:      if (stop2_p) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  assign spinning = (state == SPIN_BOTH) || (state == SPIN2);
  assign tick     = spinning && (tick_cnt == TW'(SPIN_DIV - 1));
  // A stop pulse coinciding with a tick freezes the reel at its pre-tick value.
  assign adv1     = tick && (state == SPIN_BOTH) && !stop1_p;
  assign adv2     = tick && ((state == SPIN_BOTH) || ((state == SPIN2) && !stop2_p));

  // The counter idles at 0 outside the spin states, so every entry to
  // SPIN_BOTH starts a fresh tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      reel1    <= 4'd0;
      reel2    <= 4'd0;
    end else begin
      state <= state_nx;
      if (!spinning || tick) tick_cnt <= '0;
      else                   tick_cnt <= tick_cnt + 1'b1;
      if (adv1) reel1 <= reel_add(reel1, REEL1_STEP);
      if (adv2) reel2 <= reel_add(reel2, REEL2_STEP);
    end
  end

  assign judge = (state == DONE);

`ifdef SEG7_OUT_EN
  assign seg1 = seg_decode(reel1);
  assign seg2 = seg_decode(reel2);
`else
  assign seg1 = 7'b0;
  assign seg2 = 7'b0;
`endif

endmodule

// File: tb/tb_reel_stop_ctrl.sv
// tb_reel_stop_ctrl
// Directed scoreboard bench for reel_stop_ctrl with DB_CYCLES=4, SPIN_DIV=3.
// Stimulus drives buttons on falling edges and queues the expected reel,
// judge, state and pulse-count values for a given cycle number; the monitor
// pops and compares them on the falling edge of that cycle (or at once on
// chk_now for the asynchronous reset check).
module tb_reel_stop_ctrl;
  import slot_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start, btn_stop1, btn_stop2;
  logic [3:0] reel1, reel2;
  logic       judge;
  logic [6:0] seg1, seg2;

  reel_stop_ctrl #(.DB_CYCLES(4), .SPIN_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop1(btn_stop1),
    .btn_stop2(btn_stop2), .reel1(reel1), .reel2(reel2), .judge(judge),
    .seg1(seg1), .seg2(seg2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    cyc;
    int    st, r1, r2, j, ps, p1, p2;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_ps = 0, n_p1 = 0, n_p2 = 0;
  int   n_chk = 0, n_fail = 0;
  int   seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  event chk_now;

  always @(posedge clk) begin
    cyc++;
    if (dut.u_db_start.pulse) n_ps++;
    if (dut.u_db_stop1.pulse) n_p1++;
    if (dut.u_db_stop2.pulse) n_p2++;
  end

  task automatic push(input string nm, input int c, input int st, input int r1,
                      input int r2, input int j, input int ps, input int p1, input int p2);
    exp_t e;
    e.name = nm; e.cyc = c; e.st = st; e.r1 = r1; e.r2 = r2;
    e.j = j; e.ps = ps; e.p1 = p1; e.p2 = p2;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input string fld, input int act, input int exp_v);
    if (exp_v < 0) return;
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s.%s @cyc %0d: got %0d, expected %0d", nm, fld, cyc, act, exp_v);
    end
  endtask

  function automatic int seg_exp(input int r);
    if (r < 0) return -1;
`ifdef SEG7_OUT_EN
    return seg_tab[r];
`else
    return 0;
`endif
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk(e.name, "state", int'(dut.state), e.st);
        chk(e.name, "reel1", int'(reel1), e.r1);
        chk(e.name, "reel2", int'(reel2), e.r2);
        chk(e.name, "judge", int'(judge), e.j);
        chk(e.name, "seg1", int'(seg1), seg_exp(e.r1));
        chk(e.name, "seg2", int'(seg2), seg_exp(e.r2));
        chk(e.name, "start_pulses", n_ps, e.ps);
        chk(e.name, "stop1_pulses", n_p1, e.p1);
        chk(e.name, "stop2_pulses", n_p2, e.p2);
      end
    end
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  localparam int S_IDLE = 0, S_BOTH = 1, S_SPIN2 = 2, S_DONE = 3;

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; btn_stop1 = 1'b0; btn_stop2 = 1'b0;
    push("reset", 3, S_IDLE, 0, 0, 0, 0, 0, 0);
    wait_cyc(2);
    rst_n = 1'b1;

    // start held 6 cycles: one pulse, then 4 ticks -> 4/2
    wait_cyc(4);  btn_start = 1'b1;
    push("start_wait", 10, S_IDLE, 0, 0, 0, -1, -1, -1);
    push("start_go", 11, S_BOTH, 0, 0, 0, -1, -1, -1);
    push("tick3", 22, S_BOTH, 3, 9, 0, -1, -1, -1);
    push("tick4", 23, S_BOTH, 4, 2, 0, 1, -1, -1);
    wait_cyc(10); btn_start = 1'b0;

    // 2-cycle glitch on stop1 is rejected
    wait_cyc(24); btn_stop1 = 1'b1;
    push("glitch", 34, S_BOTH, 7, 1, 0, 1, 0, -1);
    wait_cyc(26); btn_stop1 = 1'b0;

    // stop2 in SPIN_BOTH is ignored
    wait_cyc(36); btn_stop2 = 1'b1;
    push("stop2_ign", 44, S_BOTH, 1, 3, 0, -1, 0, 1);
    wait_cyc(42); btn_stop2 = 1'b0;

    // stop1 pulse coincides with a tick while reel1 = 5
    wait_cyc(52); btn_stop1 = 1'b1;
    push("pre_stop1", 58, S_BOTH, 5, 5, 0, -1, -1, -1);
    push("stop1_tick", 59, S_SPIN2, 5, 8, 0, -1, 1, -1);
    push("spin2_a", 62, S_SPIN2, 5, 1, 0, -1, -1, -1);
    push("spin2_b", 65, S_SPIN2, 5, 4, 0, -1, -1, -1);
    wait_cyc(58); btn_stop1 = 1'b0;

    // stop2 in SPIN2 with reel2 = 9 -> DONE, judge one cycle after pulse
    wait_cyc(75); btn_stop2 = 1'b1;
    push("pre_stop2", 81, S_SPIN2, 5, 9, 0, -1, -1, -1);
    push("done", 82, S_DONE, 5, 9, 1, -1, -1, 2);
    push("done_hold", 90, S_DONE, 5, 9, 1, -1, -1, -1);
    wait_cyc(81); btn_stop2 = 1'b0;

    // restart from DONE keeps held digits
    wait_cyc(92); btn_start = 1'b1;
    push("pre_restart", 98, S_DONE, 5, 9, 1, -1, -1, -1);
    push("restart", 99, S_BOTH, 5, 9, 0, -1, -1, -1);
    push("restart_hold", 101, S_BOTH, 5, 9, 0, -1, -1, -1);
    push("restart_tick", 102, S_BOTH, 6, 2, 0, -1, -1, -1);
    push("restart_pulses", 104, S_BOTH, -1, -1, 0, 2, -1, -1);
    wait_cyc(98); btn_start = 1'b0;

    // into SPIN2 again, then reset mid-spin
    wait_cyc(105); btn_stop1 = 1'b1;
    push("spin2_again", 112, S_SPIN2, 9, 1, 0, -1, -1, -1);
    push("spin2_again_t", 115, S_SPIN2, 9, 4, 0, -1, -1, -1);
    wait_cyc(111); btn_stop1 = 1'b0;

    wait_cyc(116);
    rst_n = 1'b0;
    #1;
    push("async_rst", 116, S_IDLE, 0, 0, 0, -1, -1, -1);
    -> chk_now;
    wait_cyc(118); rst_n = 1'b1;
    push("post_rst", 126, S_IDLE, 0, 0, 0, -1, -1, -1);
    push("post_rst2", 130, S_IDLE, 0, 0, 0, -1, -1, -1);

    wait_cyc(132);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: never compared, still queued at cyc %0d (due %0d)", e.name, cyc, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cyc %0d, required finish by cyc 132", cyc);
    $fatal(1, "watchdog");
  end

endmodule
